// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Brief    : Shared constants, state encoding and coin-value lookup for the
//            vending change dispenser.
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int MONEY_W   = 11;
    localparam int NUM_COINS = 6;

    // Coin flags occupy result-word bits [7:2], highest value at the LSB
    localparam int COIN_BIT_LSB = 2;
    localparam int COIN_BIT_MSB = 7;

    localparam logic [MONEY_W-1:0] COIN_VAL_50 = 11'd50;
    localparam logic [MONEY_W-1:0] COIN_VAL_20 = 11'd20;
    localparam logic [MONEY_W-1:0] COIN_VAL_10 = 11'd10;
    localparam logic [MONEY_W-1:0] COIN_VAL_5  = 11'd5;
    localparam logic [MONEY_W-1:0] COIN_VAL_2  = 11'd2;
    localparam logic [MONEY_W-1:0] COIN_VAL_1  = 11'd1;

    localparam logic [1:0] PROD_NONE = 2'd0;
    localparam logic [1:0] PROD_C    = 2'd1;
    localparam logic [1:0] PROD_S    = 2'd2;
    localparam logic [1:0] PROD_P    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DROP      = 3'd2,
        ST_DROP_WAIT = 3'd3,
        ST_COIN      = 3'd4,
        ST_GAP       = 3'd5
    } disp_state_e;

    function automatic logic [MONEY_W-1:0] coin_value(input logic [2:0] idx);
        case (idx)
            3'd0:    coin_value = COIN_VAL_50;
            3'd1:    coin_value = COIN_VAL_20;
            3'd2:    coin_value = COIN_VAL_10;
            3'd3:    coin_value = COIN_VAL_5;
            3'd4:    coin_value = COIN_VAL_2;
            3'd5:    coin_value = COIN_VAL_1;
            default: coin_value = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vend_result_fifo
// Brief    : Synchronous FIFO buffering result words ahead of the dispenser FSM.
// Revision : 1.0 - initial release
// ============================================================================
module vend_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q;
    logic [c_aw-1:0]  rd_ptr_q;
    logic [c_aw:0]    count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (count_q == (c_aw+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (c_aw+1)'(1);
                2'b01:   count_q <= count_q - (c_aw+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vend_change_dispenser
// Brief    : Serializes buffered result words into a timed product drop followed
//            by timed coin-ejector pulses. Define DISP_TIMEOUT_EN to enable the
//            drop_ack timeout and sticky fault.
// Revision : 1.0 - initial release
// ============================================================================
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic               drop_ack,
    input  logic               fault_clr,
    output logic [2:0]         product_drop,
    output logic [5:0]         coin_eject,
    output logic               busy,
    output logic [MONEY_W-1:0] change_total,
    output logic               fault
);

    localparam int c_max_pg = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_max    = (c_max_pg > ACK_TIMEOUT) ? c_max_pg : ACK_TIMEOUT;
    localparam int c_cnt_w  = $clog2(c_max + 1);

    disp_state_e              state_q, state_d;
    logic [1:0]               prod_q, prod_d;
    logic [NUM_COINS-1:0]     flags_q, flags_d;
    logic [c_cnt_w-1:0]       cnt_q, cnt_d;
    logic                     ack_seen_q, ack_seen_d;
    logic [MONEY_W-1:0]       total_q, total_d;
    logic                     fault_q, fault_d;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_push;
    logic [7:0]               w_rd_data;
    logic [2:0]               w_coin_idx;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count_unused;

    // A zero word carries nothing to dispense: handshake it but never store it
    assign w_push   = in_valid & ~w_full & (in_data != 8'h00);
    assign in_ready = ~w_full;

    vend_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (w_push),
        .pop_i     (w_pop),
        .wr_data_i (in_data),
        .rd_data_o (w_rd_data),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .count_o   (w_fifo_count_unused)
    );

    // Lowest set flag is the highest-value coin
    always_comb begin
        w_coin_idx = 3'd0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (flags_q[i]) w_coin_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            prod_q     <= PROD_NONE;
            flags_q    <= '0;
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            total_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prod_q     <= prod_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
            ack_seen_q <= ack_seen_d;
            total_q    <= total_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        prod_d     = prod_q;
        flags_d    = flags_q;
        ack_seen_d = ack_seen_q;
        total_d    = total_q;
        w_pop      = 1'b0;
`ifdef DISP_TIMEOUT_EN
        fault_d    = fault_q & ~fault_clr;
`else
        fault_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    prod_d     = w_rd_data[1:0];
                    flags_d    = w_rd_data[COIN_BIT_MSB:COIN_BIT_LSB];
                    ack_seen_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (prod_q != PROD_NONE)  state_d = ST_DROP;
                else if (flags_q != '0)   state_d = ST_COIN;
                else                      state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (drop_ack) ack_seen_d = 1'b1;
                if (cnt_q == c_cnt_w'(PULSE_CYCLES - 1)) state_d = ST_DROP_WAIT;
            end
            ST_DROP_WAIT: begin
                if (drop_ack || ack_seen_q) begin
                    state_d = (flags_q != '0) ? ST_COIN : ST_IDLE;
                end
`ifdef DISP_TIMEOUT_EN
                else if (cnt_q == c_cnt_w'(ACK_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = (flags_q != '0) ? ST_COIN : ST_IDLE;
                end
`endif
            end
            ST_COIN: begin
                if (cnt_q == c_cnt_w'(PULSE_CYCLES - 1)) begin
                    flags_d[w_coin_idx] = 1'b0;
                    total_d             = total_q + coin_value(w_coin_idx);
                    state_d             = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == c_cnt_w'(GAP_CYCLES - 1)) begin
                    state_d = (flags_q != '0) ? ST_COIN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every state's timer starts from zero on entry
        cnt_d = (state_d != state_q) ? '0 : cnt_q + c_cnt_w'(1);
    end

    always_comb begin
        product_drop = 3'b000;
        coin_eject   = 6'b000000;
        if (state_q == ST_DROP) begin
            case (prod_q)
                PROD_C:  product_drop = 3'b001;
                PROD_S:  product_drop = 3'b010;
                PROD_P:  product_drop = 3'b100;
                default: product_drop = 3'b000;
            endcase
        end
        if (state_q == ST_COIN) coin_eject = 6'b000001 << w_coin_idx;
        busy         = (state_q != ST_IDLE) | ~w_empty;
        change_total = total_q;
        fault        = fault_q;
    end

`ifndef DISP_TIMEOUT_EN
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_change_dispenser
// Brief    : Self-checking bench; solenoid events are predicted into a queue at
//            push time and compared in order as the DUT raises each pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_change_dispenser;

    localparam int PULSE = 4;
    localparam int ACK_T = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        drop_ack = 1'b0;
    logic        fault_clr = 1'b0;
    logic [2:0]  product_drop;
    logic [5:0]  coin_eject;
    logic        busy;
    logic [10:0] change_total;
    logic        fault;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;

    logic [8:0]  exp_q [$];
    logic [10:0] exp_total = 11'd0;
    int          coin_vals [6] = '{50, 20, 10, 5, 2, 1};
    logic        auto_ack = 1'b1;
    logic        man_ack = 1'b0;

    logic [8:0]  mon_sol;
    logic [8:0]  mon_prev = 9'd0;
    int          mon_width = 0;

    vend_change_dispenser dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .drop_ack     (drop_ack),
        .fault_clr    (fault_clr),
        .product_drop (product_drop),
        .coin_eject   (coin_eject),
        .busy         (busy),
        .change_total (change_total),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] d);
        logic [2:0] p;
        case (d[1:0])
            2'd1:    p = 3'b001;
            2'd2:    p = 3'b010;
            2'd3:    p = 3'b100;
            default: p = 3'b000;
        endcase
        if (p != 3'b000) exp_q.push_back({p, 6'b000000});
        for (int i = 0; i < 6; i++) begin
            if (d[2+i]) begin
                exp_q.push_back({3'b000, 6'(1 << i)});
                exp_total = exp_total + 11'(coin_vals[i]);
            end
        end
    endfunction

    task automatic push(input logic [7:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        if (d != 8'h00) model_push(d);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        repeat (3) @(negedge clk);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        check("all_served", exp_q.size(), 0);
        check("change_total", {21'd0, change_total}, {21'd0, exp_total});
    endtask

    // Chute sensor model: reports the drop while the solenoid is energised
    initial forever begin
        @(negedge clk);
        drop_ack = (auto_ack && (product_drop != 3'b000)) || man_ack;
    end

    // Solenoid monitor: one-hot, ordering against the scoreboard, pulse width
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_prev  = 9'd0;
            mon_width = 0;
        end else begin
            mon_sol = {product_drop, coin_eject};
            if (mon_sol != mon_prev) begin
                if (mon_prev != 9'd0) check("pulse_width", mon_width, PULSE);
                if (mon_sol != 9'd0) begin
                    check("onehot", 32'($countones(mon_sol)), 32'd1);
                    if (exp_q.size() == 0) check("unexpected_event", {23'd0, mon_sol}, 32'd0);
                    else check("event_order", {23'd0, mon_sol}, {23'd0, exp_q.pop_front()});
                end
                mon_width = (mon_sol != 9'd0) ? 1 : 0;
            end else if (mon_sol != 9'd0) begin
                mon_width++;
            end
            mon_prev = mon_sol;
        end
    end

    initial begin
        int n;
        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_solenoids", {23'd0, product_drop, coin_eject}, 32'd0);
        check("rst_total", {21'd0, change_total}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Product C with 20 + 2 change
        push(8'b0100_1001);
        wait_idle();
        check("total_22", {21'd0, change_total}, 32'd22);

        // Refund of 50 only, with first-pulse latency
        push(8'h04);
        @(negedge clk);
        @(negedge clk);
        check("pre_rise", {26'd0, coin_eject}, 32'd0);
        @(negedge clk);
        check("first_rise", {26'd0, coin_eject}, 32'd1);
        wait_idle();
        check("total_72", {21'd0, change_total}, 32'd72);

        // Zero word: handshaken but nothing happens
        push(8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_busy", {31'd0, busy}, 32'd0);
        end

        // Fill the FIFO while the FSM is occupied
        push(8'h07);
        n = 0;
        while (product_drop == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        push(8'h81);
        push(8'h42);
        push(8'h20);
        push(8'h10);
        @(negedge clk);
        check("full_blocks", {31'd0, in_ready}, 32'd0);
        push(8'h0B);
        wait_idle();

        // Product S with no prompt acknowledge
        auto_ack = 1'b0;
        push(8'b0001_0110);
        n = 0;
        while (product_drop == 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (product_drop != 3'b000 && n < 100) begin
            @(negedge clk);
            n++;
        end
`ifdef DISP_TIMEOUT_EN
        n = 0;
        while (!fault && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, ACK_T);
        wait_idle();
        check("fault_sticky", {31'd0, fault}, 32'd1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        check("fault_cleared", {31'd0, fault}, 32'd0);
`else
        repeat (300) @(negedge clk);
        check("waits_for_ack", exp_q.size(), 2);
        check("no_fault", {31'd0, fault}, 32'd0);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        wait_idle();
`endif
        auto_ack = 1'b1;

        // Reset in the middle of a coin pulse with a word still queued
        push(8'h04);
        push(8'h08);
        n = 0;
        while (coin_eject == 6'd0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_coin", {26'd0, coin_eject}, 32'd0);
        check("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_total", {21'd0, change_total}, 32'd0);
        check("rst_mid_flush", {31'd0, busy}, 32'd0);
        exp_q.delete();
        exp_total = 11'd0;
        @(negedge clk);
        rst = 1'b0;

        push(8'h80);
        wait_idle();
        check("total_after_rst", {21'd0, change_total}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
